// File: rtl/ffe_pkg.sv
// Shared definitions for the FFE datapath: loader FSM states, default geometry
// and bank-index constants used by the coefficient loader and sequencer.
package ffe_pkg;

  localparam int DEFAULT_DEPTH      = 4;
  localparam int DEFAULT_COEF_WIDTH = 8;
  localparam int NUM_BANKS          = 2;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  typedef enum logic {
    S_COLLECT   = 1'b0,
    S_WAIT_SWAP = 1'b1
  } loader_state_t;

endpackage

// File: rtl/ffe_coef_bank.sv
// Two-bank coefficient register file: writes land in the shadow bank, reads
// come registered from the active bank selected by i_bank_sel.
module ffe_coef_bank
  import ffe_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int COEF_WIDTH = DEFAULT_COEF_WIDTH,
  parameter int ADDR_SIZE  = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_bank_sel,
  input  logic                  i_wr_en,
  input  logic [ADDR_SIZE-1:0]  i_wr_addr,
  input  logic [COEF_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_SIZE-1:0]  i_rd_addr,
  output logic [COEF_WIDTH-1:0] o_rd_data
);

  logic [COEF_WIDTH-1:0] r_bank [NUM_BANKS][DEPTH];
  logic [COEF_WIDTH-1:0] r_rd_data;

  // NOTE: the banks are plain flops, not a RAM macro, so they can and must be
  // cleared by reset; a discarded commit must never leak stale taps.
  // NOTE: non-blocking assignments keep the read of the old bank and the
  // shadow write in the same edge independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int t = 0; t < DEPTH; t++) begin
          r_bank[b][t] <= '0;
        end
      end
      r_rd_data <= '0;
    end else begin
      if (i_wr_en) r_bank[~i_bank_sel][i_wr_addr] <= i_wr_data;
      if (i_rd_en) r_rd_data <= r_bank[i_bank_sel][i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ffe_coeff_loader.sv
// Double-buffered FFE coefficient loader: collects a full tap set into the
// shadow bank and swaps banks only on a symbol boundary.
module ffe_coeff_loader
  import ffe_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int COEF_WIDTH = DEFAULT_COEF_WIDTH,
  parameter int ADDR_SIZE  = $clog2(DEPTH)
) (
  input  logic                  ffe_clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [ADDR_SIZE-1:0]  cfg_addr,
  input  logic [COEF_WIDTH-1:0] cfg_data,
  input  logic                  cfg_last,
  input  logic                  sym_boundary,
  input  logic                  rd_en,
  input  logic [ADDR_SIZE-1:0]  rd_addr,
  output logic [COEF_WIDTH-1:0] coef_out,
  output logic                  bank_sel,
  output logic                  commit_pending,
  output logic                  cfg_done,
  output logic                  cfg_err
);

  loader_state_t    r_state;
  logic [DEPTH-1:0] r_mask;
  logic             r_bank_sel;
  logic             r_cfg_ready;
  logic             r_commit_pending;
  logic             r_cfg_done;
  logic             r_cfg_err;

  logic             w_accept;
  logic             w_addr_ok;
  logic [DEPTH-1:0] w_onehot;
  logic             w_set_full;

  // Out-of-range addresses only exist when DEPTH is not a power of two.
  if ((1 << ADDR_SIZE) == DEPTH) begin : g_addr_pow2
    assign w_addr_ok = 1'b1;
  end else begin : g_addr_range
    localparam logic [ADDR_SIZE:0] LP_DEPTH = DEPTH[ADDR_SIZE:0];
    assign w_addr_ok = ({1'b0, cfg_addr} < LP_DEPTH);
  end

  assign w_accept   = cfg_valid && r_cfg_ready;
  assign w_onehot   = {{(DEPTH-1){1'b0}}, 1'b1} << cfg_addr;
  assign w_set_full = &(r_mask | w_onehot);

  always_ff @(posedge ffe_clk) begin
    if (rst) begin
      r_state          <= S_COLLECT;
      r_mask           <= '0;
      r_bank_sel       <= BANK_A;
      r_cfg_ready      <= 1'b0;
      r_commit_pending <= 1'b0;
      r_cfg_done       <= 1'b0;
      r_cfg_err        <= 1'b0;
    end else begin
      r_cfg_done <= 1'b0;
      r_cfg_err  <= 1'b0;
      unique case (r_state)
        S_COLLECT: begin
          r_cfg_ready <= 1'b1;
          if (w_accept) begin
            if (cfg_last) begin
              r_mask <= '0;
              // A boundary on this same edge is deliberately ignored: the
              // swap waits for the next full symbol.
              if (w_addr_ok && w_set_full) begin
                r_state          <= S_WAIT_SWAP;
                r_cfg_ready      <= 1'b0;
                r_commit_pending <= 1'b1;
              end else begin
                r_cfg_err <= 1'b1;
              end
            end else if (w_addr_ok) begin
              r_mask <= r_mask | w_onehot;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        S_WAIT_SWAP: begin
          if (sym_boundary) begin
            r_state          <= S_COLLECT;
            r_bank_sel       <= ~r_bank_sel;
            r_cfg_ready      <= 1'b1;
            r_commit_pending <= 1'b0;
            r_cfg_done       <= 1'b1;
          end
        end
      endcase
    end
  end

  ffe_coef_bank #(
    .DEPTH      (DEPTH),
    .COEF_WIDTH (COEF_WIDTH),
    .ADDR_SIZE  (ADDR_SIZE)
  ) u_bank (
    .i_clk      (ffe_clk),
    .i_rst      (rst),
    .i_bank_sel (r_bank_sel),
    .i_wr_en    (w_accept && w_addr_ok),
    .i_wr_addr  (cfg_addr),
    .i_wr_data  (cfg_data),
    .i_rd_en    (rd_en),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (coef_out)
  );

  assign cfg_ready      = r_cfg_ready;
  assign bank_sel       = r_bank_sel;
  assign commit_pending = r_commit_pending;
  assign cfg_done       = r_cfg_done;
  assign cfg_err        = r_cfg_err;

endmodule

// File: tb/tb_ffe_coeff_loader.sv
// Self-checking bench for ffe_coeff_loader: a tap-set/bank model checked every
// cycle, plus directed literal expectations at the interesting edges.
module tb_ffe_coeff_loader;

  localparam int DEPTH = 4;
  localparam int CW    = 8;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_last = 1'b0;
  logic          sym_boundary = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [CW-1:0] cfg_data = '0;

  logic          cfg_ready;
  logic [CW-1:0] coef_out;
  logic          bank_sel;
  logic          commit_pending;
  logic          cfg_done;
  logic          cfg_err;

  always #5 clk = ~clk;

  ffe_coeff_loader #(.DEPTH(DEPTH), .COEF_WIDTH(CW), .ADDR_SIZE(AW)) dut (
    .ffe_clk        (clk),
    .rst            (rst),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_addr       (cfg_addr),
    .cfg_data       (cfg_data),
    .cfg_last       (cfg_last),
    .sym_boundary   (sym_boundary),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .coef_out       (coef_out),
    .bank_sel       (bank_sel),
    .commit_pending (commit_pending),
    .cfg_done       (cfg_done),
    .cfg_err        (cfg_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Behavioural model: two tap tables, which one is live, whether a complete
  // set is waiting, and which taps of the set in progress have been written.
  logic [CW-1:0] m_bank [2][DEPTH];
  bit            m_live;
  bit            m_pending;
  bit            m_written [DEPTH];
  bit            m_ready;
  bit            m_done;
  bit            m_err;
  logic [CW-1:0] m_coef;
  bit            m_started = 1'b0;

  always @(posedge clk) begin
    int  n_written;
    bit  live_now;
    m_started = 1'b1;
    if (rst) begin
      foreach (m_bank[b, t]) m_bank[b][t] = '0;
      foreach (m_written[t]) m_written[t] = 1'b0;
      m_live = 1'b0; m_pending = 1'b0; m_ready = 1'b0;
      m_done = 1'b0; m_err = 1'b0; m_coef = '0;
    end else begin
      live_now = m_live;
      m_done = 1'b0;
      m_err  = 1'b0;
      if (rd_en) m_coef = m_bank[live_now][rd_addr];
      if (!m_pending) begin
        if (cfg_valid && m_ready) begin
          m_bank[!live_now][cfg_addr] = cfg_data;
          m_written[cfg_addr] = 1'b1;
          if (cfg_last) begin
            n_written = 0;
            foreach (m_written[t]) if (m_written[t]) n_written++;
            if (n_written == DEPTH) m_pending = 1'b1;
            else m_err = 1'b1;
            foreach (m_written[t]) m_written[t] = 1'b0;
          end
        end
      end else if (sym_boundary) begin
        m_live    = !m_live;
        m_pending = 1'b0;
        m_done    = 1'b1;
      end
      m_ready = !m_pending;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("coef_out",       32'(coef_out),       32'(m_coef));
      check("bank_sel",       32'(bank_sel),       32'(m_live));
      check("commit_pending", 32'(commit_pending), 32'(m_pending));
      check("cfg_done",       32'(cfg_done),       32'(m_done));
      check("cfg_err",        32'(cfg_err),        32'(m_err));
      check("cfg_ready",      32'(cfg_ready),      32'(m_ready));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int a, input logic [CW-1:0] d, input bit last);
    cfg_valid = 1'b1;
    cfg_addr  = a[AW-1:0];
    cfg_data  = d;
    cfg_last  = last;
    step();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  logic [CW-1:0] exp_set [DEPTH];

  initial begin
    // Reset and post-reset read of an all-zero active bank.
    rst = 1'b1;
    step(); step();
    check("lit_ready_in_reset", 32'(cfg_ready), 32'd0);
    rst = 1'b0;
    step();
    check("lit_ready_after_reset", 32'(cfg_ready), 32'd1);
    check("lit_bank_sel_reset", 32'(bank_sel), 32'd0);
    rd_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = i[AW-1:0];
      step();
      check("lit_reset_tap", 32'(coef_out), 32'd0);
    end

    // Full set, last on tap 0, reads of tap 0 running throughout.
    rd_addr = '0;
    beat(3, 8'h10, 1'b0);
    beat(2, 8'hF0, 1'b0);
    beat(1, 8'h7F, 1'b0);
    beat(0, 8'h80, 1'b1);
    check("lit_pending_after_last", 32'(commit_pending), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("lit_pending_hold", 32'(commit_pending), 32'd1);
      check("lit_old_coef_hold", 32'(coef_out), 32'd0);
    end
    sym_boundary = 1'b1;
    step();
    sym_boundary = 1'b0;
    check("lit_done_pulse", 32'(cfg_done), 32'd1);
    check("lit_bank_sel_1", 32'(bank_sel), 32'd1);
    check("lit_read_at_swap_old", 32'(coef_out), 32'd0);
    step();
    check("lit_done_clear", 32'(cfg_done), 32'd0);
    check("lit_tap0_new", 32'(coef_out), 32'h80);
    exp_set = '{8'h80, 8'h7F, 8'hF0, 8'h10};
    for (int i = 1; i < DEPTH; i++) begin
      rd_addr = i[AW-1:0];
      step();
      check("lit_tap_new", 32'(coef_out), 32'(exp_set[i]));
    end

    // Incomplete set: only taps 0 and 2 before cfg_last.
    beat(0, 8'h11, 1'b0);
    beat(2, 8'h22, 1'b1);
    check("lit_err_pulse", 32'(cfg_err), 32'd1);
    check("lit_no_pending", 32'(commit_pending), 32'd0);
    sym_boundary = 1'b1;
    step();
    sym_boundary = 1'b0;
    check("lit_err_clear", 32'(cfg_err), 32'd0);
    check("lit_no_swap_in_collect", 32'(bank_sel), 32'd1);

    // Full set with a rewrite of tap 0; cfg_last coincides with a boundary.
    beat(0, 8'h09, 1'b0);
    beat(1, 8'h02, 1'b0);
    beat(2, 8'h03, 1'b0);
    beat(0, 8'h01, 1'b0);
    sym_boundary = 1'b1;
    beat(3, 8'h04, 1'b1);
    sym_boundary = 1'b0;
    check("lit_coincident_no_swap", 32'(bank_sel), 32'd1);
    check("lit_coincident_pending", 32'(commit_pending), 32'd1);
    cfg_valid = 1'b1; cfg_addr = 2'd1; cfg_data = 8'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      check("lit_ready_low_in_wait", 32'(cfg_ready), 32'd0);
    end
    sym_boundary = 1'b1;
    step();
    sym_boundary = 1'b0;
    cfg_valid = 1'b0;
    check("lit_second_done", 32'(cfg_done), 32'd1);
    check("lit_bank_sel_0", 32'(bank_sel), 32'd0);
    exp_set = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = i[AW-1:0];
      step();
      check("lit_set2_tap", 32'(coef_out), 32'(exp_set[i]));
    end

    // Reset while a commit is pending discards it.
    beat(0, 8'hA0, 1'b0);
    beat(1, 8'hA1, 1'b0);
    beat(2, 8'hA2, 1'b0);
    beat(3, 8'hA3, 1'b1);
    check("lit_pending_before_rst", 32'(commit_pending), 32'd1);
    rst = 1'b1;
    step();
    check("lit_rst_coef", 32'(coef_out), 32'd0);
    check("lit_rst_pending", 32'(commit_pending), 32'd0);
    check("lit_rst_bank_sel", 32'(bank_sel), 32'd0);
    rst = 1'b0;
    step();
    sym_boundary = 1'b1;
    step();
    sym_boundary = 1'b0;
    check("lit_no_done_after_rst", 32'(cfg_done), 32'd0);
    check("lit_bank_sel_stays", 32'(bank_sel), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = i[AW-1:0];
      step();
      check("lit_zero_after_rst", 32'(coef_out), 32'd0);
    end

    rd_en = 1'b0;
    step(); step();
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
